// File: rtl/mdl_dmabe_pkg.sv
// ---------------------------------------------------------------------------
// mdl_dmabe_pkg
// Shared definitions for the 005297 DMA backend: FSM state encoding, the
// ROT8 phase indices at which each bus event is decoded, and the transfer
// direction constants.
// ---------------------------------------------------------------------------
package mdl_dmabe_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ARM      = 3'd1,
        ST_WAIT_ACT = 3'd2,
        ST_XFER     = 3'd3,
        ST_DONE     = 3'd4
    } state_e;

    // Bit positions in the one-hot ROT8 ring.
    localparam int PH_ALD  = 0;  // address stable, word cycle begins
    localparam int PH_AS   = 3;  // AS falls (and DS on writes)
    localparam int PH_RDS  = 4;  // DS falls on reads
    localparam int PH_PUSH = 6;  // buffer push on reads
    localparam int PH_ADV  = 7;  // strobes rise, address/count advance

    localparam logic DIR_WRITE = 1'b0;  // buffer -> RAM
    localparam logic DIR_READ  = 1'b1;  // RAM -> buffer

endpackage

// File: rtl/mdl_dmabe_cnt.sv
// ---------------------------------------------------------------------------
// mdl_dmabe_cnt
// Word-address incrementer plus transfer-length down-counter.
//   i_MCLK, i_SYS_RST : clock, synchronous active-high reset
//   i_CE              : clock enable; reset is honoured only on enabled edges
//   i_LOAD            : capture i_START_ADDR / i_LEN
//   i_ADV             : address += 1 (mod 2^ADDR_W), count -= 1 (mod 2^CNT_W)
//   o_ADDR            : current word address
//   o_LAST            : the word in progress is the final one (count == 1)
// A length of 0 loads 0, which wraps on the first decrement and therefore
// yields 2^CNT_W words before o_LAST is seen.
// ---------------------------------------------------------------------------
module mdl_dmabe_cnt #(
    parameter int ADDR_W = 23,
    parameter int CNT_W  = 10
) (
    input  logic              i_MCLK,
    input  logic              i_SYS_RST,
    input  logic              i_CE,
    input  logic              i_LOAD,
    input  logic [ADDR_W-1:0] i_START_ADDR,
    input  logic [CNT_W-1:0]  i_LEN,
    input  logic              i_ADV,
    output logic [ADDR_W-1:0] o_ADDR,
    output logic              o_LAST
);

    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  cnt_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_MCLK) begin
        if (i_CE) begin
            if (i_SYS_RST) begin
                addr_q <= '0;
                cnt_q  <= '0;
            end else if (i_LOAD) begin
                addr_q <= i_START_ADDR;
                cnt_q  <= i_LEN;
            end else if (i_ADV) begin
                addr_q <= addr_q + ADDR_W'(1);
                cnt_q  <= cnt_q - CNT_W'(1);
            end
        end
    end

    assign o_ADDR = addr_q;
    assign o_LAST = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/mdl_dmabe.sv
// ---------------------------------------------------------------------------
// mdl_dmabe
// DMA backend for the 005297 bus-master path. Requests the bus from the
// frontend, then runs one 68000 word cycle per ROT8 rotation while granted.
//   i_MCLK, i_SYS_RST      : clock, synchronous active-high reset
//   i_CLK4M_PCEN_n         : active-low clock enable (gates reset as well)
//   i_ROT8                 : one-hot phase ring
//   i_DMA_ACT, i_ALD_EN    : bus grant / address-drive enable from frontend
//   i_REQ, i_DIR, i_START_ADDR, i_XFER_LEN : block request from page buffer
//   o_BR_START_n, o_DMA_END: handshake to frontend
//   o_ADDR, o_ADDR_OE, o_AS_n, o_DS_n, o_RW : 68000 bus drive
//   o_BUF_POP, o_BUF_PUSH  : page-buffer strobes
//   o_BUSY                 : not idle
// Every output is a register whose next value is decoded from the next
// state and the current ROT8 phase, giving a fixed one-enable latency and
// letting an abort release the strobes on the very next enabled edge.
// ---------------------------------------------------------------------------
module mdl_dmabe
    import mdl_dmabe_pkg::*;
#(
    parameter int ADDR_W = 23,
    parameter int CNT_W  = 10
) (
    input  logic              i_MCLK,
    input  logic              i_SYS_RST,
    input  logic              i_CLK4M_PCEN_n,
    input  logic [7:0]        i_ROT8,
    input  logic              i_DMA_ACT,
    input  logic              i_ALD_EN,
    input  logic              i_REQ,
    input  logic              i_DIR,
    input  logic [ADDR_W-1:0] i_START_ADDR,
    input  logic [CNT_W-1:0]  i_XFER_LEN,
    output logic              o_BR_START_n,
    output logic              o_DMA_END,
    output logic [ADDR_W-1:0] o_ADDR,
    output logic              o_ADDR_OE,
    output logic              o_AS_n,
    output logic              o_DS_n,
    output logic              o_RW,
    output logic              o_BUF_POP,
    output logic              o_BUF_PUSH,
    output logic              o_BUSY
);

    logic   ce;
    state_e state_q, state_d;
    logic   dir_q;
    logic   word_q, word_d;   // a word cycle has begun (ROT8[0] seen in XFER)
    logic   act_q;            // previous i_DMA_ACT, for the WAIT_ACT abort edge
    logic   load, adv, last;

    logic   br_start_n_q, br_start_n_d;
    logic   dma_end_q, dma_end_d;
    logic   addr_oe_q, addr_oe_d;
    logic   as_n_q, as_n_d;
    logic   ds_n_q, ds_n_d;
    logic   rw_q, rw_d;
    logic   pop_q, pop_d;
    logic   push_q, push_d;
    logic   busy_q, busy_d;

    logic   xfer_d, in_word, as_win, rds_win;
    logic   unused_rot;

    assign ce   = ~i_CLK4M_PCEN_n;
    assign load = (state_q == ST_IDLE) & i_REQ;
    // Abort (DMA_ACT low) suppresses the advance so the last-word phase can
    // never reach DONE when the grant drops in the same cycle.
    assign adv  = (state_q == ST_XFER) & word_q & i_DMA_ACT & i_ROT8[PH_ADV];

    // Phases 1 and 2 carry no bus event.
    assign unused_rot = ^i_ROT8[PH_AS-1:PH_ALD+1];

    mdl_dmabe_cnt #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_cnt (
        .i_MCLK       (i_MCLK),
        .i_SYS_RST    (i_SYS_RST),
        .i_CE         (ce),
        .i_LOAD       (load),
        .i_START_ADDR (i_START_ADDR),
        .i_LEN        (i_XFER_LEN),
        .i_ADV        (adv),
        .o_ADDR       (o_ADDR),
        .o_LAST       (last)
    );

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:     if (i_REQ) state_d = ST_ARM;
            ST_ARM:      state_d = ST_WAIT_ACT;
            ST_WAIT_ACT: begin
                if (i_DMA_ACT)  state_d = ST_XFER;
                else if (act_q) state_d = ST_IDLE;
            end
            ST_XFER: begin
                if (!i_DMA_ACT)       state_d = ST_IDLE;
                else if (adv && last) state_d = ST_DONE;
            end
            ST_DONE:     if (!i_DMA_ACT) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Output decode from next state and the current ROT8 phase.
    always_comb begin
        xfer_d  = (state_d == ST_XFER);
        word_d  = xfer_d & (word_q | ((state_q == ST_XFER) & i_ROT8[PH_ALD]));
        in_word = xfer_d & word_q;
        as_win  = |i_ROT8[PH_ADV-1:PH_AS];
        rds_win = |i_ROT8[PH_ADV-1:PH_RDS];

        br_start_n_d = (state_d != ST_ARM);
        dma_end_d    = (state_d == ST_DONE);
        busy_d       = (state_d != ST_IDLE);
        addr_oe_d    = xfer_d & i_ALD_EN;
        rw_d         = xfer_d ? dir_q : 1'b1;
        as_n_d       = ~(in_word & as_win);
        ds_n_d       = ~(in_word & ((dir_q == DIR_WRITE) ? as_win : rds_win));
        pop_d        = in_word & (dir_q == DIR_WRITE) & i_ROT8[PH_AS];
        push_d       = in_word & (dir_q == DIR_READ) & i_ROT8[PH_PUSH];
    end

    always_ff @(posedge i_MCLK) begin
        if (ce) begin
            if (i_SYS_RST) begin
                state_q      <= ST_IDLE;
                dir_q        <= DIR_WRITE;
                word_q       <= 1'b0;
                act_q        <= 1'b0;
                br_start_n_q <= 1'b1;
                dma_end_q    <= 1'b0;
                addr_oe_q    <= 1'b0;
                as_n_q       <= 1'b1;
                ds_n_q       <= 1'b1;
                rw_q         <= 1'b1;
                pop_q        <= 1'b0;
                push_q       <= 1'b0;
                busy_q       <= 1'b0;
            end else begin
                state_q      <= state_d;
                if (load) dir_q <= i_DIR;
                word_q       <= word_d;
                act_q        <= i_DMA_ACT;
                br_start_n_q <= br_start_n_d;
                dma_end_q    <= dma_end_d;
                addr_oe_q    <= addr_oe_d;
                as_n_q       <= as_n_d;
                ds_n_q       <= ds_n_d;
                rw_q         <= rw_d;
                pop_q        <= pop_d;
                push_q       <= push_d;
                busy_q       <= busy_d;
            end
        end
    end

    assign o_BR_START_n = br_start_n_q;
    assign o_DMA_END    = dma_end_q;
    assign o_ADDR_OE    = addr_oe_q;
    assign o_AS_n       = as_n_q;
    assign o_DS_n       = ds_n_q;
    assign o_RW         = rw_q;
    assign o_BUF_POP    = pop_q;
    assign o_BUF_PUSH   = push_q;
    assign o_BUSY       = busy_q;

endmodule

// File: tb/tb_mdl_dmabe.sv
// ---------------------------------------------------------------------------
// tb_mdl_dmabe
// Directed bench for mdl_dmabe (CNT_W = 4). Expected word cycles are queued
// when a transfer is launched and popped whenever the DUT strobes the buffer.
// ---------------------------------------------------------------------------
module tb_mdl_dmabe;

    localparam int AW = 23;
    localparam int CW = 4;

    typedef struct {
        logic [AW-1:0] addr;
        logic          rw;
        logic          push;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          pcen_n;
    logic [7:0]    rot;
    logic          act, ald_en, req, dir;
    logic [AW-1:0] start_addr;
    logic [CW-1:0] xfer_len;

    logic          o_BR_START_n, o_DMA_END, o_ADDR_OE, o_AS_n, o_DS_n, o_RW;
    logic          o_BUF_POP, o_BUF_PUSH, o_BUSY;
    logic [AW-1:0] o_ADDR;

    exp_t sb_q[$];
    int   vectors = 0;
    int   errors  = 0;
    int   strobe_cnt = 0;
    int   as_age = 0;
    logic cur_dir = 1'b0;

    always #5 clk = ~clk;

    mdl_dmabe #(.ADDR_W(AW), .CNT_W(CW)) dut (
        .i_MCLK         (clk),
        .i_SYS_RST      (rst),
        .i_CLK4M_PCEN_n (pcen_n),
        .i_ROT8         (rot),
        .i_DMA_ACT      (act),
        .i_ALD_EN       (ald_en),
        .i_REQ          (req),
        .i_DIR          (dir),
        .i_START_ADDR   (start_addr),
        .i_XFER_LEN     (xfer_len),
        .o_BR_START_n   (o_BR_START_n),
        .o_DMA_END      (o_DMA_END),
        .o_ADDR         (o_ADDR),
        .o_ADDR_OE      (o_ADDR_OE),
        .o_AS_n         (o_AS_n),
        .o_DS_n         (o_DS_n),
        .o_RW           (o_RW),
        .o_BUF_POP      (o_BUF_POP),
        .o_BUF_PUSH     (o_BUF_PUSH),
        .o_BUSY         (o_BUSY)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        vectors++;
        assert (obs === expd) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expd);
        end
    endtask

    // Scoreboard and strobe-timing monitor, run once per enabled cycle.
    task automatic monitor();
        exp_t e;
        if (o_BUF_POP || o_BUF_PUSH) begin
            strobe_cnt++;
            if (sb_q.size() == 0) begin
                check("strobe_without_expect", {30'd0, o_BUF_PUSH, o_BUF_POP}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("strobe_kind", {30'd0, o_BUF_PUSH, o_BUF_POP}, e.push ? 32'd2 : 32'd1);
                check("strobe_addr", 32'(o_ADDR), 32'(e.addr));
                check("strobe_rw", 32'(o_RW), 32'(e.rw));
                check("strobe_as_low", 32'(o_AS_n), 32'd0);
                check("strobe_addr_oe", 32'(o_ADDR_OE), 32'd1);
                // rot already holds the phase after the one that caused it
                check("strobe_phase", 32'(rot), e.push ? 32'h80 : 32'h10);
            end
        end
        if (o_AS_n === 1'b0) as_age++;
        else                 as_age = 0;
        if (as_age == 1) check("ds_at_as_fall", 32'(o_DS_n), cur_dir ? 32'd1 : 32'd0);
        if (as_age == 2) check("ds_after_as_fall", 32'(o_DS_n), 32'd0);
    endtask

    // One enabled cycle: a disabled MCLK edge followed by an enabled one.
    task automatic tick();
        @(negedge clk) pcen_n = 1'b1;
        @(negedge clk) pcen_n = 1'b0;
        @(posedge clk);
        #1;
        rot = {rot[6:0], rot[7]};
        monitor();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_br"},   32'(o_BR_START_n), 32'd1);
        check({tag, "_end"},  32'(o_DMA_END), 32'd0);
        check({tag, "_addr"}, 32'(o_ADDR), 32'd0);
        check({tag, "_oe"},   32'(o_ADDR_OE), 32'd0);
        check({tag, "_as"},   32'(o_AS_n), 32'd1);
        check({tag, "_ds"},   32'(o_DS_n), 32'd1);
        check({tag, "_rw"},   32'(o_RW), 32'd1);
        check({tag, "_pop"},  32'(o_BUF_POP), 32'd0);
        check({tag, "_push"}, 32'(o_BUF_PUSH), 32'd0);
        check({tag, "_busy"}, 32'(o_BUSY), 32'd0);
    endtask

    task automatic push_words(input logic [AW-1:0] a, input int n, input logic d);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.addr = a + AW'(i);
            e.rw   = d;
            e.push = d;
            sb_q.push_back(e);
        end
    endtask

    task automatic issue_req(input logic [AW-1:0] a, input logic [CW-1:0] len, input logic d);
        cur_dir    = d;
        start_addr = a;
        xfer_len   = len;
        dir        = d;
        req        = 1'b1;
        tick();
        check("br_start_low", 32'(o_BR_START_n), 32'd0);
        check("busy_after_req", 32'(o_BUSY), 32'd1);
    endtask

    task automatic wait_end(input int budget);
        int n = 0;
        while (o_DMA_END !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check("dma_end_seen", 32'(o_DMA_END), 32'd1);
        check("dma_end_after_adv", 32'(rot), 32'h01);
        check("as_released_at_end", 32'(o_AS_n), 32'd1);
        check("words_outstanding", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic finish_xfer(input logic [AW-1:0] fin_addr);
        logic [AW-1:0] fa;
        fa = fin_addr;
        check("addr_after_xfer", 32'(o_ADDR), 32'(fa));
        for (int i = 0; i < 4; i++) begin
            tick();
            check("dma_end_held", 32'(o_DMA_END), 32'd1);
        end
        act = 1'b0;
        tick();
        check("dma_end_clear", 32'(o_DMA_END), 32'd0);
        check("idle_after_done", 32'(o_BUSY), 32'd0);
    endtask

    task automatic run_xfer(input logic [AW-1:0] a, input int words, input logic [CW-1:0] len,
                            input logic d, input int gap);
        issue_req(a, len, d);
        req = 1'b0;
        tick();
        check("br_start_one_cycle", 32'(o_BR_START_n), 32'd1);
        for (int i = 0; i < gap; i++) tick();
        push_words(a, words, d);
        act = 1'b1;
        wait_end(words * 8 + 24);
        finish_xfer(a + AW'(words));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, n;
        rst = 1'b1; pcen_n = 1'b1; rot = 8'h01;
        act = 1'b0; ald_en = 1'b1; req = 1'b0; dir = 1'b0;
        start_addr = '0; xfer_len = '0;

        // Reset and idle
        tick(); tick();
        rst = 1'b0;
        check_reset_vals("reset");
        for (int i = 0; i < 20; i++) tick();
        check_reset_vals("idle20");

        // Write: 3 words from 0x100
        run_xfer(23'h000100, 3, 4'd3, 1'b0, 3);

        // Read: 1 word at top of address space, address wraps
        run_xfer(23'h7FFFFF, 1, 4'd1, 1'b1, 2);

        // Length 0 -> 2^CNT_W words
        run_xfer(23'h000200, 16, 4'd0, 1'b0, 1);

        // Abort mid-word 2 of 5
        issue_req(23'h000300, 4'd5, 1'b0);
        req = 1'b0;
        tick(); tick();
        push_words(23'h000300, 2, 1'b0);
        base = strobe_cnt;
        act = 1'b1;
        n = 0;
        while (strobe_cnt - base < 2 && n < 64) begin tick(); n++; end
        check("abort_reached_word2", 32'(strobe_cnt - base), 32'd2);
        act = 1'b0;
        tick();
        check("abort_as", 32'(o_AS_n), 32'd1);
        check("abort_ds", 32'(o_DS_n), 32'd1);
        check("abort_busy", 32'(o_BUSY), 32'd0);
        check("abort_oe", 32'(o_ADDR_OE), 32'd0);
        check("abort_rw", 32'(o_RW), 32'd1);
        for (int i = 0; i < 24; i++) tick();
        check("abort_no_end", 32'(o_DMA_END), 32'd0);
        check("abort_no_strobes", 32'(strobe_cnt - base), 32'd2);
        run_xfer(23'h000400, 2, 4'd2, 1'b1, 1);

        // Reset during XFER
        issue_req(23'h000500, 4'd4, 1'b0);
        req = 1'b0;
        tick();
        push_words(23'h000500, 4, 1'b0);
        base = strobe_cnt;
        act = 1'b1;
        n = 0;
        while (strobe_cnt - base < 1 && n < 32) begin tick(); n++; end
        check("rst_reached_word1", 32'(strobe_cnt - base), 32'd1);
        rst = 1'b1;
        tick();
        check_reset_vals("midrst");
        sb_q.delete();
        rst = 1'b0;
        act = 1'b0;
        tick();

        // REQ held high through WAIT_ACT is not re-armed
        issue_req(23'h000600, 4'd1, 1'b1);
        tick();
        check("held_req_br_end", 32'(o_BR_START_n), 32'd1);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("held_req_no_rearm", 32'(o_BR_START_n), 32'd1);
        end
        push_words(23'h000600, 1, 1'b1);
        act = 1'b1;
        wait_end(40);
        req = 1'b0;
        finish_xfer(23'h000601);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
